// File: rtl/ejector.sv
`default_nettype none
// ejector: removes at most one locally addressed flit per cycle into a small FIFO
// and forwards all other flits with one register stage. Optional stats: EJECT_STATS_EN.
module ejector #(
  parameter int MY_X  = 1,
  parameter int MY_Y  = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  northad,
  input  logic [9:0]  southad,
  input  logic [9:0]  eastad,
  input  logic [9:0]  westad,
  input  logic        n_vld,
  input  logic        s_vld,
  input  logic        e_vld,
  input  logic        w_vld,
  output logic [9:0]  nad,
  output logic [9:0]  sad,
  output logic [9:0]  ead,
  output logic [9:0]  wad,
  output logic        nad_vld,
  output logic        sad_vld,
  output logic        ead_vld,
  output logic        wad_vld,
  output logic [9:0]  localad,
  output logic        local_vld,
  input  logic        local_rdy,
`ifdef EJECT_STATS_EN
  output logic [15:0] ej_count,
  output logic [15:0] defl_count,
`endif
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [5:0] MY_ADDR = {3'(MY_X), 3'(MY_Y)};

  // Lane order: 0 east, 1 west, 2 north, 3 south
  logic [9:0]    in_data [4];
  logic [3:0]    in_vld;
  logic [3:0]    is_local, is_golden, cand, ej_mask;
  logic          found, eject, pop;
  logic [1:0]    win_idx, idx;

  logic [9:0]    lane_data_q [4];
  logic [9:0]    lane_data_d [4];
  logic [3:0]    lane_vld_q, lane_vld_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_data[0] = eastad;
  assign in_data[1] = westad;
  assign in_data[2] = northad;
  assign in_data[3] = southad;
  assign in_vld     = {s_vld, n_vld, w_vld, e_vld};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign is_local[i]  = in_vld[i] && (in_data[i][5:0] == MY_ADDR);
      assign is_golden[i] = is_local[i] && in_data[i][9];
    end
  endgenerate

  // Golden local flits shadow the non-golden ones entirely
  assign cand = (|is_golden) ? is_golden : is_local;

  always_comb begin
    found   = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && cand[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot
  assign eject   = found && (cnt_q < CW'(DEPTH));
  assign pop     = (cnt_q != '0) && local_rdy;
  assign ej_mask = eject ? (4'b0001 << win_idx) : 4'b0000;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_data_d[i] = (in_vld[i] && !ej_mask[i]) ? in_data[i] : 10'd0;
      lane_vld_d[i]  = in_vld[i] && !ej_mask[i];
    end
    ptr_d = eject ? (win_idx + 2'd1) : ptr_q;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (eject) mem_d[wr_q] = in_data[win_idx];
    wr_d = eject ? (wr_q + AW'(1)) : wr_q;
    rd_d = pop ? (rd_q + AW'(1)) : rd_q;
    case ({eject, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) lane_data_q[i] <= 10'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 10'd0;
      lane_vld_q <= 4'd0;
      ptr_q      <= 2'd0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      for (int i = 0; i < 4; i++) lane_data_q[i] <= lane_data_d[i];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      lane_vld_q <= lane_vld_d;
      ptr_q      <= ptr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ead       = lane_data_q[0];
  assign wad       = lane_data_q[1];
  assign nad       = lane_data_q[2];
  assign sad       = lane_data_q[3];
  assign ead_vld   = lane_vld_q[0];
  assign wad_vld   = lane_vld_q[1];
  assign nad_vld   = lane_vld_q[2];
  assign sad_vld   = lane_vld_q[3];
  assign local_vld = (cnt_q != '0);
  assign localad   = local_vld ? mem_q[rd_q] : 10'd0;
  assign fifo_cnt  = cnt_q;

`ifdef EJECT_STATS_EN
  logic [15:0] ej_count_q, ej_count_d, defl_count_q, defl_count_d;
  logic        deflected;

  assign deflected = |(is_local & ~ej_mask);

  always_comb begin
    ej_count_d   = (eject && ej_count_q != 16'hFFFF) ? ej_count_q + 16'd1 : ej_count_q;
    defl_count_d = (deflected && defl_count_q != 16'hFFFF) ? defl_count_q + 16'd1 : defl_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ej_count_q   <= 16'd0;
      defl_count_q <= 16'd0;
    end else begin
      ej_count_q   <= ej_count_d;
      defl_count_q <= defl_count_d;
    end
  end

  assign ej_count   = ej_count_q;
  assign defl_count = defl_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ejector.sv
`default_nettype none
// tb_ejector: directed vectors; expected ejections/forwards queued per step,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_ejector;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] northad, southad, eastad, westad;
  logic       n_vld, s_vld, e_vld, w_vld;
  logic [9:0] nad, sad, ead, wad;
  logic       nad_vld, sad_vld, ead_vld, wad_vld;
  logic [9:0] localad;
  logic       local_vld, local_rdy;
  logic [2:0] fifo_cnt;
`ifdef EJECT_STATS_EN
  logic [15:0] ej_count, defl_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] exp_local [$];
  logic [9:0] exp_e [$];
  logic [9:0] exp_w [$];
  logic [9:0] exp_n [$];
  logic [9:0] exp_s [$];

  always #5 clk = ~clk;

  ejector #(.MY_X(1), .MY_Y(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
    .n_vld(n_vld), .s_vld(s_vld), .e_vld(e_vld), .w_vld(w_vld),
    .nad(nad), .sad(sad), .ead(ead), .wad(wad),
    .nad_vld(nad_vld), .sad_vld(sad_vld), .ead_vld(ead_vld), .wad_vld(wad_vld),
    .localad(localad), .local_vld(local_vld), .local_rdy(local_rdy),
`ifdef EJECT_STATS_EN
    .ej_count(ej_count), .defl_count(defl_count),
`endif
    .fifo_cnt(fifo_cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flit addressed to this node (X=1, Y=2)
  function automatic logic [9:0] lf(input logic g, input logic [2:0] tag);
    return {g, tag, 6'b001010};
  endfunction

  task automatic mon_lane(input string name, input int lane, input logic v, input logic [9:0] d);
    logic [9:0] e;
    if (v) begin
      int sz;
      case (lane)
        0: sz = exp_e.size();
        1: sz = exp_w.size();
        2: sz = exp_n.size();
        default: sz = exp_s.size();
      endcase
      if (sz == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s unexpected forward: got %h expected none", name, d);
      end else begin
        case (lane)
          0: e = exp_e.pop_front();
          1: e = exp_w.pop_front();
          2: e = exp_n.pop_front();
          default: e = exp_s.pop_front();
        endcase
        chk(name, {6'd0, d}, {6'd0, e});
      end
    end else begin
      chk({name, "_idle_zero"}, {6'd0, d}, 16'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_lane("ead", 0, ead_vld, ead);
      mon_lane("wad", 1, wad_vld, wad);
      mon_lane("nad", 2, nad_vld, nad);
      mon_lane("sad", 3, sad_vld, sad);
      if (local_vld && local_rdy) begin
        if (exp_local.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL localad unexpected pop: got %h expected none", localad);
        end else begin
          chk("localad_pop", {6'd0, localad}, {6'd0, exp_local.pop_front()});
        end
      end
    end
  end

  // ej: lane index hand-determined to be ejected this step, -1 for none
  task automatic step(input logic [9:0] e, w, n, s, input logic [3:0] v,
                      input logic rdy, input int ej);
    logic [9:0] d [4];
    d[0] = e; d[1] = w; d[2] = n; d[3] = s;
    eastad = e; westad = w; northad = n; southad = s;
    e_vld = v[0]; w_vld = v[1]; n_vld = v[2]; s_vld = v[3];
    local_rdy = rdy;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (i == ej) exp_local.push_back(d[i]);
        else case (i)
          0: exp_e.push_back(d[i]);
          1: exp_w.push_back(d[i]);
          2: exp_n.push_back(d[i]);
          default: exp_s.push_back(d[i]);
        endcase
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    step(10'd0, 10'd0, 10'd0, 10'd0, 4'b0000, rdy, -1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_fifo_cnt"}, {13'd0, fifo_cnt}, 16'd0);
    chk({tag, "_local_vld"}, {15'd0, local_vld}, 16'd0);
    chk({tag, "_localad"}, {6'd0, localad}, 16'd0);
    chk({tag, "_lane_vld"}, {12'd0, ead_vld, wad_vld, nad_vld, sad_vld}, 16'd0);
    chk({tag, "_lane_or"}, {6'd0, ead | wad | nad | sad}, 16'd0);
`ifdef EJECT_STATS_EN
    chk({tag, "_ej_count"}, ej_count, 16'd0);
    chk({tag, "_defl_count"}, defl_count, 16'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    eastad = '0; westad = '0; northad = '0; southad = '0;
    e_vld = 0; w_vld = 0; n_vld = 0; s_vld = 0; local_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // Golden south beats east at pointer 0; pointer stays 0, east forwarded
    step(lf(0, 0), 10'd0, 10'd0, lf(1, 0), 4'b1001, 1'b0, 3);
    chk("golden_cnt", {13'd0, fifo_cnt}, 16'd1);
    chk("golden_head", {6'd0, localad}, 16'h20A);
    // East alone next cycle is ejected
    step(lf(0, 0), 10'd0, 10'd0, 10'd0, 4'b0001, 1'b0, 0);
    chk("single_cnt", {13'd0, fifo_cnt}, 16'd2);
    chk("single_vld", {15'd0, local_vld}, 16'd1);
    // Non-local north flit passes through
    step(10'd0, 10'd0, 10'b0000100111, 10'd0, 4'b0100, 1'b0, -1);
    chk("pass_cnt", {13'd0, fifo_cnt}, 16'd2);
    idle(1'b1);
    idle(1'b1);
    chk("drain1_cnt", {13'd0, fifo_cnt}, 16'd0);
    chk("drain1_head", {6'd0, localad}, 16'd0);

    // Pointer is 1; a south eject brings it back to 0
    step(10'd0, 10'd0, 10'd0, lf(0, 1), 4'b1000, 1'b0, 3);
    idle(1'b1);

    // Round robin E, W, N, S with continuous drain
    for (int c = 0; c < 4; c++) begin
      step(lf(0, 1), lf(0, 2), lf(0, 3), lf(0, 4), 4'b1111, 1'b1, c);
      chk("rr_cnt", {13'd0, fifo_cnt}, 16'd1);
    end
    idle(1'b1);
    chk("rr_drain_cnt", {13'd0, fifo_cnt}, 16'd0);

    // Fill to DEPTH, fifth flit deflected, sixth deflected despite a pop
    for (int c = 0; c < 4; c++) step(lf(0, 3'(c + 1)), 10'd0, 10'd0, 10'd0, 4'b0001, 1'b0, 0);
    chk("full_cnt", {13'd0, fifo_cnt}, 16'd4);
    step(lf(0, 5), 10'd0, 10'd0, 10'd0, 4'b0001, 1'b0, -1);
    chk("full5_cnt", {13'd0, fifo_cnt}, 16'd4);
    step(lf(0, 6), 10'd0, 10'd0, 10'd0, 4'b0001, 1'b1, -1);
    chk("fullpop_cnt", {13'd0, fifo_cnt}, 16'd3);
    repeat (3) idle(1'b1);
    chk("full_drain_cnt", {13'd0, fifo_cnt}, 16'd0);
    chk("full_drain_head", {6'd0, localad}, 16'd0);
    chk("full_drain_vld", {15'd0, local_vld}, 16'd0);

    // Mid-operation reset with three queued and one in-flight flit
    for (int c = 0; c < 3; c++) step(lf(0, 3'(c)), 10'd0, 10'd0, 10'd0, 4'b0001, 1'b0, 0);
    chk("pre_rst_cnt", {13'd0, fifo_cnt}, 16'd3);
    rst = 1'b1;
    eastad = '0; e_vld = 1'b0;
    northad = 10'b0000100111; n_vld = 1'b1;
    @(posedge clk); #1;
    exp_local.delete(); exp_e.delete(); exp_w.delete(); exp_n.delete(); exp_s.delete();
    chk_reset_state("midrst");
    rst = 1'b0;
    // Pointer back at east (it was west before reset)
    step(lf(0, 1), lf(0, 2), lf(0, 3), lf(0, 4), 4'b1111, 1'b0, 0);
    chk("post_rst_head", {6'd0, localad}, {6'd0, lf(0, 1)});
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    chk("exp_local_empty", 16'(exp_local.size()), 16'd0);
    chk("exp_fwd_empty", 16'(exp_e.size() + exp_w.size() + exp_n.size() + exp_s.size()), 16'd0);
    chk("final_cnt", {13'd0, fifo_cnt}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ejector.md
Name: ejector

Overview:
- Ejection stage of the bufferless deflection router; sits directly upstream of the injector on the same four port lanes (0 east, 1 west, 2 north, 3 south).
- Each cycle, removes at most one flit addressed to this node and queues it to the local sink through a small FIFO.
- Frees that flit's slot so the injector can reuse it. All other flits pass through with one register stage.

Parameters:
- MY_X, 1, node X coordinate, compared against flit bits [5:3]
- MY_Y, 2, node Y coordinate, compared against flit bits [2:0]
- DEPTH, 4, ejection FIFO entries; power of two, 2..16

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- northad, southad, eastad, westad  in  10 each  incoming flits
- n_vld, s_vld, e_vld, w_vld  in  1 each  incoming flit valid
- nad, sad, ead, wad  out  10 each  flits forwarded to injector
- nad_vld, sad_vld, ead_vld, wad_vld  out  1 each  forwarded valid
- localad  out  10  FIFO head flit to local sink
- local_vld  out  1  FIFO non-empty
- local_rdy  in  1  local sink accepts head this cycle
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Flit format: [9] golden/priority, [8:6] tag, [5:3] dest X, [2:0] dest Y.
- A flit is local when its valid is 1 and [5:0] == {MY_X,MY_Y}.
- Reset (rst=1 at a clk edge): all outputs 0, FIFO empty, fifo_cnt=0, round-robin pointer=0 (east). Mid-operation reset discards FIFO contents and in-flight flits.
- Arbitration is combinational on the current inputs:
  - Local flits with [9]=1 take precedence over non-golden local flits.
  - Within the same priority class, the winner is the first local lane at or after the pointer, in order 0 east, 1 west, 2 north, 3 south, wrapping.
- Eject condition: a winner exists and fifo_cnt < DEPTH. No push-while-full, even if a pop happens in the same cycle.
- On eject:
  - Winner is pushed to the FIFO.
  - The winner's lane output next cycle has data=0, vld=0.
  - Pointer becomes (winner index + 1) mod 4.
- No eject: pointer holds.
- Forwarding: every non-ejected lane registers its input data and valid unchanged, 1-cycle latency. This includes losing local flits, which the next router deflects.
- FIFO:
  - Pop when local_vld && local_rdy.
  - Push and pop in the same cycle leaves fifo_cnt unchanged.
  - localad shows the head flit; it is 0 when empty.
  - Read and write pointers wrap modulo DEPTH.
- Invalid lanes (vld=0) are never ejected; their data is forwarded as 0.

Optional Feature:
- Macro EJECT_STATS_EN.
- When defined:
  - Adds outputs ej_count (16 bits) and defl_count (16 bits), both reset to 0.
  - ej_count increments per ejected flit.
  - defl_count increments once per cycle in which at least one local flit is forwarded rather than ejected, whether it lost arbitration or the FIFO was full.
  - Both counters saturate at 16'hFFFF.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Single eject: reset, then eastad=10'b0000001010 (e_vld=1), other lanes invalid, local_rdy=0 -> next cycle ead_vld=0, local_vld=1, localad=10'b0000001010, fifo_cnt=1, pointer=1.
- Pass-through: northad=10'b0000100111 (n_vld=1, dest not local) -> next cycle nad=10'b0000100111, nad_vld=1, fifo_cnt unchanged.
- Golden priority and round-robin: pointer=0, eastad=10'b0000001010 and southad=10'b1000001010 both valid -> south ejected; ead=10'b0000001010 forwarded with ead_vld=1; pointer=0. Next cycle, with only the east flit again, east is ejected.
- Round-robin fairness: all four lanes carry non-golden local flits for 4 cycles, local_rdy=1 -> ejected lanes in order E, W, N, S; fifo_cnt peaks at 1.
- FIFO full: DEPTH=4, local_rdy=0, one local flit per cycle for 5 cycles -> fifo_cnt=4; the 5th flit is forwarded (vld=1). Then assert local_rdy with no new flits -> four pops in FIFO order, fifo_cnt reaches 0, localad=0.
- Mid-operation reset: fifo_cnt=3, rst=1 for one cycle -> fifo_cnt=0, local_vld=0, all lane valids 0, pointer=0 (with EJECT_STATS_EN, counters=0).
